// File: rtl/reg_bus_mux.sv
// ============================================================================
// Module   : reg_bus_mux
// Brief    : Registered N-channel bus multiplexer with manual load and
//            optional round-robin scan (enabled by REG_BUS_MUX_SCAN_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_bus_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_n,
  input  logic [WIDTH*CHANNELS-1:0] data_in,
  input  logic [SEL_W-1:0]          select,
  input  logic                      load,
  input  logic                      scan,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          chan,
  output logic                      sel_err,
  output logic                      wrap
);

  localparam logic [SEL_W:0] c_chan_count = (SEL_W+1)'(CHANNELS);

  if (CHANNELS < 2 || CHANNELS > 16 || (1 << SEL_W) < CHANNELS) begin : g_param_err
    $error("reg_bus_mux: CHANNELS must be 2..16 and fit in SEL_W bits");
  end

  logic [WIDTH-1:0] w_chan_word [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign w_chan_word[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Out-of-range select falls through to zero instead of indexing past the bus.
  logic [WIDTH-1:0] w_sel_word;
  logic             w_sel_ok;

  always_comb begin
    w_sel_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (select == SEL_W'(k)) w_sel_word = w_chan_word[k];
    end
  end

  assign w_sel_ok = ({1'b0, select} < c_chan_count);

  logic [WIDTH-1:0] r_y,       w_y_nxt;
  logic             r_y_valid, w_y_valid_nxt;
  logic [SEL_W-1:0] r_chan,    w_chan_nxt;
  logic             r_sel_err, w_sel_err_nxt;

`ifdef REG_BUS_MUX_SCAN_EN
  localparam logic [SEL_W-1:0] c_last = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] r_cnt,  w_cnt_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic [WIDTH-1:0] w_cnt_word;

  always_comb begin
    w_cnt_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_cnt == SEL_W'(k)) w_cnt_word = w_chan_word[k];
    end
  end
`else
  logic w_unused_scan;
  assign w_unused_scan = scan ^ hold;
`endif

  // Priority: enable_n, then scan (held or advancing), then manual load.
  always_comb begin
    w_y_nxt       = r_y;
    w_y_valid_nxt = r_y_valid;
    w_chan_nxt    = r_chan;
    w_sel_err_nxt = 1'b0;
`ifdef REG_BUS_MUX_SCAN_EN
    w_cnt_nxt     = r_cnt;
    w_wrap_nxt    = 1'b0;
`endif
    if (enable_n) begin
      w_y_nxt       = '0;
      w_y_valid_nxt = 1'b0;
    end
`ifdef REG_BUS_MUX_SCAN_EN
    else if (scan) begin
      if (!hold) begin
        w_y_nxt       = w_cnt_word;
        w_y_valid_nxt = 1'b1;
        w_chan_nxt    = r_cnt;
        if (r_cnt == c_last) begin
          w_cnt_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_cnt_nxt  = r_cnt + 1'b1;
        end
      end
    end
`endif
    else if (load) begin
      if (w_sel_ok) begin
        w_y_nxt       = w_sel_word;
        w_y_valid_nxt = 1'b1;
        w_chan_nxt    = select;
`ifdef REG_BUS_MUX_SCAN_EN
        w_cnt_nxt     = select;
`endif
      end else begin
        w_y_nxt       = '0;
        w_y_valid_nxt = 1'b0;
        w_sel_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_chan    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_y       <= w_y_nxt;
      r_y_valid <= w_y_valid_nxt;
      r_chan    <= w_chan_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

`ifdef REG_BUS_MUX_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign wrap = r_wrap;
`else
  assign wrap = 1'b0;
`endif

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign chan    = r_chan;
  assign sel_err = r_sel_err;

endmodule

`default_nettype wire
